// File: rtl/fabm_pkg.sv
// Shared constants and helpers for the FABM multiplier back-end blocks.
package fabm_pkg;

  localparam int unsigned PROD_W    = 22;
  localparam int unsigned PROD_LSB  = 10;
  localparam int unsigned LEN_DEF   = 16;
  localparam int unsigned ACC_W_DEF = 40;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned n = 1; n < v; n = n << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fabm_acc_add.sv
// Sign-extending accumulate adder with two's-complement overflow detect.
module fabm_acc_add
  import fabm_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] ext;

  assign ext   = ACC_W'($signed(prod_i));
  assign sum_o = acc_i + ext;
  // Overflow only when both operands share a sign that the sum does not.
  assign ovf_o = (acc_i[ACC_W-1] == ext[ACC_W-1]) && (sum_o[ACC_W-1] != acc_i[ACC_W-1]);

endmodule

// File: rtl/fabm_prod_accum.sv
// Frame accumulator for FABM products: input register, LEN-product sum,
// single-entry result buffer with valid/ready handoff.
module fabm_prod_accum
  import fabm_pkg::*;
#(
  parameter int unsigned LEN   = LEN_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  localparam int unsigned     CNT_W    = clog2(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic              prod_v_q, prod_v_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]  sum;
  logic              add_ovf;
  logic              last, stall, add_en;

  fabm_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_i  (acc_q),
    .prod_i (prod_q),
    .sum_o  (sum),
    .ovf_o  (add_ovf)
  );

  assign last     = (cnt_q == CNT_LAST);
  assign stall    = prod_v_q && last && out_valid_q && !out_ready;
  assign add_en   = prod_v_q && !stall;
  assign in_ready = in_clear || !stall;

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    prod_v_d    = prod_v_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_clear) begin
      prod_v_d  = 1'b0;
      acc_d     = '0;
      ovf_acc_d = 1'b0;
      cnt_d     = '0;
    end else begin
      if (in_valid && in_ready) begin
        prod_d   = in_prod;
        prod_v_d = 1'b1;
      end else if (!stall) begin
        prod_v_d = 1'b0;
      end

      if (add_en) begin
        if (last) begin
          // A completing frame overrides the handoff clear so nothing is lost.
          out_acc_d   = sum;
          out_ovf_d   = ovf_acc_q | add_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_acc_d   = 1'b0;
          cnt_d       = '0;
        end else begin
          acc_d     = sum;
          ovf_acc_d = ovf_acc_q | add_ovf;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_v_q    <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      prod_v_q    <= prod_v_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_fabm_prod_accum.sv
// Directed bench for fabm_prod_accum: a LEN=4/ACC_W=40 instance and a
// LEN=4/ACC_W=23 instance driven by the same stimulus.
module tb_fabm_prod_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [21:0] in_prod;
  logic        in_clear;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [39:0] out_acc_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [22:0] out_acc_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fabm_prod_accum #(.LEN(4), .ACC_W(40)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_prod   (in_prod),
    .in_clear  (in_clear),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_acc   (out_acc_a),
    .out_ovf   (out_ovf_a)
  );

  fabm_prod_accum #(.LEN(4), .ACC_W(23)) u_narrow (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_prod   (in_prod),
    .in_clear  (in_clear),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_acc   (out_acc_b),
    .out_ovf   (out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [21:0] v);
    in_valid = 1'b1;
    in_prod  = v;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_clear  = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_in_ready",  64'(in_ready_a),  64'd1);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_acc",   64'(out_acc_a),   64'd0);
    chk("rst_out_ovf",   64'(out_ovf_a),   64'd0);
    rst_n = 1'b1;
    cyc();

    // Basic frame 1+2+3+4
    feed(22'd1); feed(22'd2); feed(22'd3); feed(22'd4);
    in_valid = 1'b0;
    #1;
    chk("t1_lat_valid0", 64'(out_valid_a), 64'd0);
    idle();
    chk("t1_valid",      64'(out_valid_a), 64'd1);
    chk("t1_acc",        64'(out_acc_a),   64'd10);
    chk("t1_ovf",        64'(out_ovf_a),   64'd0);
    idle();
    chk("t1_pulse_end",  64'(out_valid_a), 64'd0);

    // Negative products, back-to-back frames
    feed(22'h3FFFFF); feed(22'h3FFFFF); feed(22'h3FFFFF); feed(22'h3FFFFF);
    feed(22'h200000);
    chk("t2_valid_a",    64'(out_valid_a), 64'd1);
    chk("t2_acc_neg4",   64'(out_acc_a),   64'h00FF_FFFF_FFFC);
    chk("t2_ovf_a",      64'(out_ovf_a),   64'd0);
    feed(22'h200000);
    chk("t2_valid_drop", 64'(out_valid_a), 64'd0);
    feed(22'h200000); feed(22'h200000);
    idle();
    chk("t2_valid_b",    64'(out_valid_a), 64'd1);
    chk("t2_acc_min",    64'(out_acc_a),   64'h00FF_FF80_0000);
    idle();

    // Backpressure: 8 ones with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(22'd1);
      if (i == 4) begin
        chk("t3_first_valid", 64'(out_valid_a), 64'd1);
        chk("t3_first_acc",   64'(out_acc_a),   64'd4);
      end
    end
    in_valid = 1'b0;
    #1;
    chk("t3_stall_ready",  64'(in_ready_a),  64'd0);
    chk("t3_hold_acc",     64'(out_acc_a),   64'd4);
    idle();
    chk("t3_stall_ready2", 64'(in_ready_a),  64'd0);
    chk("t3_hold_valid",   64'(out_valid_a), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("t3_ready_back",   64'(in_ready_a),  64'd1);
    idle();
    chk("t3_second_valid", 64'(out_valid_a), 64'd1);
    chk("t3_second_acc",   64'(out_acc_a),   64'd4);
    idle();
    chk("t3_drained",      64'(out_valid_a), 64'd0);

    // Clear mid-frame while a result is pending
    out_ready = 1'b0;
    feed(22'd2); feed(22'd2); feed(22'd2); feed(22'd2);
    feed(22'd5); feed(22'd5);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_prod  = 22'd7;
    #1;
    chk("t4_clear_ready",  64'(in_ready_a),  64'd1);
    cyc();
    in_clear = 1'b0;
    chk("t4_pend_valid",   64'(out_valid_a), 64'd1);
    chk("t4_pend_acc",     64'(out_acc_a),   64'd8);
    feed(22'd1); feed(22'd1); feed(22'd1); feed(22'd1);
    in_valid = 1'b0;
    #1;
    chk("t4_pend_hold",    64'(out_acc_a),   64'd8);
    out_ready = 1'b1;
    idle();
    chk("t4_post_valid",   64'(out_valid_a), 64'd1);
    chk("t4_post_acc",     64'(out_acc_a),   64'd4);
    idle();
    chk("t4_drained",      64'(out_valid_a), 64'd0);

    // Overflow on the 23-bit instance
    feed(22'h1FFFFF); feed(22'h1FFFFF); feed(22'h1FFFFF); feed(22'h1FFFFF);
    feed(22'd1);
    chk("t5_nar_valid",    64'(out_valid_b), 64'd1);
    chk("t5_nar_acc",      64'(out_acc_b),   64'h7F_FFFC);
    chk("t5_nar_ovf",      64'(out_ovf_b),   64'd1);
    chk("t5_wide_acc",     64'(out_acc_a),   64'h7F_FFFC);
    chk("t5_wide_ovf",     64'(out_ovf_a),   64'd0);
    feed(22'd1); feed(22'd1); feed(22'd1);
    idle();
    chk("t5_clean_acc",    64'(out_acc_b),   64'd4);
    chk("t5_clean_ovf",    64'(out_ovf_b),   64'd0);
    idle();

    // Asynchronous reset mid-frame with a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) feed(22'd1);
    in_valid = 1'b0;
    chk("t6_pre_valid",    64'(out_valid_a), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",    64'(out_valid_a), 64'd0);
    chk("t6_rst_acc",      64'(out_acc_a),   64'd0);
    chk("t6_rst_ovf",      64'(out_ovf_a),   64'd0);
    chk("t6_rst_ready",    64'(in_ready_a),  64'd1);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    feed(22'd2); feed(22'd2); feed(22'd2); feed(22'd2);
    idle();
    chk("t6_after_valid",  64'(out_valid_a), 64'd1);
    chk("t6_after_acc",    64'(out_acc_a),   64'd8);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
